// File: rtl/dc_pkg.sv
// Shared types and duty helpers for the DC motor ramp scheduler.
package dc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DEAD = 2'd2
  } dc_state_e;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

  // Commands above full scale are treated as full scale.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
    logic [DUTY_W-1:0] res;
    if (duty > DUTY_MAX) begin
      res = DUTY_MAX;
    end else begin
      res = duty;
    end
    return res;
  endfunction

endpackage

// File: rtl/dc_ramp_sched_if.sv
// Target duty/direction command handshake into the ramp scheduler.
interface dc_ramp_sched_if;
  import dc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_dir;

  modport master (output cmd_valid, output cmd_duty, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_duty, input cmd_dir, output cmd_ready);

endinterface

// File: rtl/dc_tick_gen.sv
// Free-running microsecond and duty-step prescalers; only rst clears them.
module dc_tick_gen #(
  parameter int CLK_FRE = 50,
  parameter int STEP_US = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick,
  output logic step_tick
);

  localparam int US_W   = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam int STEP_W = (STEP_US > 1) ? $clog2(STEP_US) : 1;
  localparam logic [US_W-1:0]   US_LAST   = US_W'(CLK_FRE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_US - 1);

  logic [US_W-1:0]   us_cnt_q, us_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  // Tick decode and counter advance.
  always_comb begin
    us_tick   = (us_cnt_q == US_LAST);
    step_tick = us_tick && (step_cnt_q == STEP_LAST);
    if (us_tick) begin
      us_cnt_d = '0;
    end else begin
      us_cnt_d = us_cnt_q + US_W'(1);
    end
    if (step_tick) begin
      step_cnt_d = '0;
    end else if (us_tick) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q   <= '0;
      step_cnt_q <= '0;
    end else begin
      us_cnt_q   <= us_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

endmodule

// File: rtl/dc_ramp_sched.sv
// Soft-start / reversal scheduler: ramps PWM duty 1% per step, brakes through a
// dead time before flipping direction.
module dc_ramp_sched
  import dc_pkg::*;
#(
  parameter int CLK_FRE = 50,
  parameter int STEP_US = 1000,
  parameter int DEAD_US = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              estop,
  dc_ramp_sched_if.slave    cmd,
  output logic [DUTY_W-1:0] dc_duty,
  output logic              dc_dir,
  output logic              busy,
  output logic              brake
);

  localparam int DEAD_W = (DEAD_US > 1) ? $clog2(DEAD_US) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_US - 1);

  dc_state_e         state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              dir_q, dir_d;
  logic              pend_q, pend_d;
  logic              pend_dir_q, pend_dir_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;

  logic              us_tick_s, step_tick_s;
  logic              cmd_ready_s, accept_s;
  logic [DUTY_W-1:0] eff_target_s, step_duty_s, cmd_duty_s;

  dc_tick_gen #(
    .CLK_FRE (CLK_FRE),
    .STEP_US (STEP_US)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .us_tick   (us_tick_s),
    .step_tick (step_tick_s)
  );

  // A pending reversal forces the ramp toward zero before the dead time.
  always_comb begin
    cmd_ready_s  = !estop && (state_q != DEAD);
    accept_s     = cmd.cmd_valid && cmd_ready_s;
    cmd_duty_s   = clamp_duty(cmd.cmd_duty);
    eff_target_s = pend_q ? 8'd0 : target_q;
    if (duty_q < eff_target_s) begin
      step_duty_s = duty_q + 8'd1;
    end else if (duty_q > eff_target_s) begin
      step_duty_s = duty_q - 8'd1;
    end else begin
      step_duty_s = duty_q;
    end
  end

  // Next-state logic: estop beats commands; an accepted command overrides the
  // state decision taken by the ramp/dead handling.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    dead_cnt_d = '0;
    if (estop) begin
      state_d  = IDLE;
      duty_d   = 8'd0;
      target_d = 8'd0;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RAMP: begin
          if (step_tick_s) begin
            duty_d = step_duty_s;
          end else begin
            duty_d = duty_q;
          end
          if (duty_d == eff_target_s) begin
            state_d = pend_q ? DEAD : IDLE;
          end else begin
            state_d = RAMP;
          end
        end
        DEAD: begin
          duty_d     = 8'd0;
          dead_cnt_d = dead_cnt_q;
          if (us_tick_s && (dead_cnt_q == DEAD_LAST)) begin
            dir_d   = pend_dir_q;
            pend_d  = 1'b0;
            state_d = (target_q != 8'd0) ? RAMP : IDLE;
          end else if (us_tick_s) begin
            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
          end else begin
            dead_cnt_d = dead_cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = 8'd0;
        end
      endcase

      if (accept_s) begin
        target_d = cmd_duty_s;
        if ((cmd.cmd_dir == dir_q) || (duty_q == 8'd0)) begin
          dir_d   = cmd.cmd_dir;
          pend_d  = 1'b0;
          state_d = (cmd_duty_s != duty_d) ? RAMP : IDLE;
        end else begin
          pend_d     = 1'b1;
          pend_dir_d = cmd.cmd_dir;
          state_d    = RAMP;
        end
      end else begin
        target_d = target_d;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= 8'd0;
      target_q   <= 8'd0;
      dir_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_s;
  assign dc_duty       = duty_q;
  assign dc_dir        = dir_q;
  assign busy          = (state_q != IDLE);
  assign brake         = (state_q == DEAD);

endmodule
